// File: rtl/piece_bag_queue_pkg.sv
// Shared definitions for the 7-bag piece generator: piece codes, bag mask, LFSR taps, FSM states.
package piece_bag_queue_pkg;

    localparam logic [2:0]  PIECE_EMPTY       = 3'd7;
    localparam logic [6:0]  BAG_FULL          = 7'h7F;
    // Fibonacci feedback taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        PBQ_FILL  = 2'd0,
        PBQ_FULL  = 2'd1,
        PBQ_FLUSH = 2'd2
    } pbq_state_t;

    function automatic logic [2:0] bag_count(input logic [6:0] mask);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/piece_bag_queue_lfsr.sv
// 16-bit Fibonacci LFSR for piece sampling; a zero seed is replaced by the default seed.
module piece_lfsr
    import piece_bag_queue_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] sample
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;

    // Free-running in every state so player timing feeds entropy into the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign sample = lfsr_q[2:0];

endmodule

// File: rtl/piece_bag_queue.sv
// 7-bag piece generator feeding a small FIFO of upcoming pieces; head piece is registered.
// Optional build macro PREVIEW_EN adds a registered `preview` output of the second FIFO entry.
module piece_bag_queue
    import piece_bag_queue_pkg::*;
#(
    parameter int          DEPTH = 3,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       take,
    output logic [2:0] piece,
    output logic       piece_valid,
    output logic [2:0] bag_left,
`ifdef PREVIEW_EN
    output logic [2:0] preview,
`endif
    output pbq_state_t dbg_state,
    output logic [3:0] dbg_count
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0]  LAST_P  = PW'(DEPTH - 1);

    logic [2:0]    cand;
    pbq_state_t    state_q, state_d;
    logic [2:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [6:0]    mask_q, mask_d, mask_clr;
    logic [2:0]    piece_d;
    logic          push, pop;

    piece_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (cand)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        mask_d   = mask_q;
        mask_clr = mask_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (restart) begin
            state_d = PBQ_FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            mask_d  = BAG_FULL;
        end else begin
            case (state_q)
                PBQ_FILL, PBQ_FULL: begin
                    // Reject sampling: draws of 7 or already-dealt pieces are simply dropped.
                    push = (state_q == PBQ_FILL) && (cand != PIECE_EMPTY) &&
                           mask_q[cand] && (count_q < DEPTH_C);
                    pop  = take && (count_q != '0);
                    if (push) begin
                        tail_d   = ptr_inc(tail_q);
                        mask_clr = mask_q & ~(7'b1 << cand);
                        mask_d   = (mask_clr == 7'h00) ? BAG_FULL : mask_clr;
                    end
                    if (pop) begin
                        head_d = ptr_inc(head_q);
                    end
                    if (push && !pop) begin
                        count_d = count_q + 1'b1;
                    end else if (pop && !push) begin
                        count_d = count_q - 1'b1;
                    end
                    state_d = (count_d == DEPTH_C) ? PBQ_FULL : PBQ_FILL;
                end
                default: state_d = PBQ_FILL;
            endcase
        end
    end

    // Next head value, with the entry being written this edge forwarded.
    always_comb begin
        piece_d = PIECE_EMPTY;
        if (count_d != '0) begin
            piece_d = (push && tail_q == head_d) ? cand : mem_q[head_d];
        end
    end

`ifdef PREVIEW_EN
    logic [2:0]    preview_d;
    logic [PW-1:0] head_n1;

    always_comb begin
        head_n1   = ptr_inc(head_d);
        preview_d = PIECE_EMPTY;
        if (count_d > CW'(1)) begin
            preview_d = (push && tail_q == head_n1) ? cand : mem_q[head_n1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preview <= PIECE_EMPTY;
        end else begin
            preview <= preview_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PBQ_FILL;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mask_q      <= BAG_FULL;
            piece       <= PIECE_EMPTY;
            piece_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mask_q      <= mask_d;
            piece       <= piece_d;
            piece_valid <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= cand;
        end
    end

    assign bag_left  = bag_count(mask_q);
    assign dbg_state = state_q;
    assign dbg_count = 4'(count_q);

endmodule

// File: tb/tb_piece_bag_queue.sv
// Bench for piece_bag_queue: queue-based reference model checked every cycle, plus directed takes/restarts.
module tb_piece_bag_queue;
    import piece_bag_queue_pkg::*;

    localparam int DEPTH = 3;

    logic       clk, rst_n, restart, take;
    logic [2:0] piece, bag_left, piece0, bag_left0;
    logic       piece_valid, piece_valid0;
    pbq_state_t dbg_state, dbg_state0;
    logic [3:0] dbg_count, dbg_count0;
`ifdef PREVIEW_EN
    logic [2:0] preview, preview0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    piece_bag_queue #(.DEPTH(DEPTH), .SEED(16'hACE1)) u_dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .take(take),
        .piece(piece), .piece_valid(piece_valid), .bag_left(bag_left),
`ifdef PREVIEW_EN
        .preview(preview),
`endif
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    // Zero seed must behave exactly like the default seed.
    piece_bag_queue #(.DEPTH(DEPTH), .SEED(16'h0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .restart(restart), .take(take),
        .piece(piece0), .piece_valid(piece_valid0), .bag_left(bag_left0),
`ifdef PREVIEW_EN
        .preview(preview0),
`endif
        .dbg_state(dbg_state0), .dbg_count(dbg_count0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: upcoming pieces as a queue, current bag as a set of undealt pieces.
    logic [15:0] m_lfsr;
    logic [2:0]  m_q[$];
    logic [6:0]  m_bag;
    bit          m_flush;

    always @(posedge clk or negedge rst_n) begin
        logic [2:0] c;
        bit can_push;
        if (!rst_n) begin
            m_lfsr  = 16'hACE1;
            m_q.delete();
            m_bag   = 7'h7F;
            m_flush = 1'b0;
        end else begin
            c = m_lfsr[2:0];
            if (restart) begin
                m_q.delete();
                m_bag   = 7'h7F;
                m_flush = 1'b1;
            end else if (m_flush) begin
                m_flush = 1'b0;
            end else begin
                can_push = (c != 3'd7) && m_bag[c] && (m_q.size() < DEPTH);
                if (take && m_q.size() > 0) void'(m_q.pop_front());
                if (can_push) begin
                    m_q.push_back(c);
                    m_bag[c] = 1'b0;
                    if (m_bag == 7'h00) m_bag = 7'h7F;
                end
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    logic [2:0] prev_bl;
    bit         wrap_seen;

    always @(negedge clk) begin
        logic [31:0] e_piece, e_state;
        e_piece = (m_q.size() > 0) ? 32'(m_q[0]) : 32'd7;
        e_state = m_flush ? 32'(PBQ_FLUSH) : ((m_q.size() == DEPTH) ? 32'(PBQ_FULL) : 32'(PBQ_FILL));
        check("piece",     32'(piece),       e_piece);
        check("valid",     32'(piece_valid), 32'(m_q.size() > 0));
        check("bag_left",  32'(bag_left),    32'($countones(m_bag)));
        check("count",     32'(dbg_count),   32'(m_q.size()));
        check("state",     32'(dbg_state),   e_state);
        check("seed0_piece", 32'(piece0),    e_piece);
        check("seed0_bag",   32'(bag_left0), 32'($countones(m_bag)));
`ifdef PREVIEW_EN
        check("preview", 32'(preview), (m_q.size() > 1) ? 32'(m_q[1]) : 32'd7);
`endif
        if (rst_n && prev_bl == 3'd1 && bag_left == 3'd7) wrap_seen = 1'b1;
        prev_bl = bag_left;
    end

    logic [2:0] taken[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic take_one();
        int w;
        w = 0;
        while (!piece_valid && w < 200) begin
            cyc();
            w++;
        end
        if (!piece_valid) begin
            check("take_wait_timeout", 32'd0, 32'd1);
        end else begin
            taken.push_back(piece);
            take = 1'b1;
            cyc();
            take = 1'b0;
            repeat (3) cyc();
        end
    endtask

    task automatic check_perm(input string name, input int base);
        logic [6:0] seen;
        seen = 7'h00;
        for (int i = base; i < base + 7; i++) begin
            if (taken[i] != 3'd7) seen[taken[i]] = 1'b1;
        end
        check(name, 32'(seen), 32'h7F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int w;
        rst_n = 1'b0; restart = 1'b0; take = 1'b0;
        wrap_seen = 1'b0; prev_bl = 3'd7;
        repeat (2) cyc();
        check("rst_piece", 32'(piece), 32'd7);
        check("rst_valid", 32'(piece_valid), 32'd0);
        check("rst_bag_left", 32'(bag_left), 32'd7);
        check("rst_count", 32'(dbg_count), 32'd0);

        // Seed 0xACE1 draws 1 on the first edge after release.
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("first_piece", 32'(piece), 32'd1);
        check("first_valid", 32'(piece_valid), 32'd1);
        check("first_bag_left", 32'(bag_left), 32'd6);

        for (int i = 0; i < 14; i++) take_one();
        check("taken_count", 32'(taken.size()), 32'd14);
        if (taken.size() == 14) begin
            check("take0", 32'(taken[0]), 32'd1);
            check("take1", 32'(taken[1]), 32'd3);
            check("take2", 32'(taken[2]), 32'd6);
            check_perm("bag_perm_1", 0);
            check_perm("bag_perm_2", 7);
        end
        check("bag_left_wrap", 32'(wrap_seen), 32'd1);

        // Restart mid-bag, with a simultaneous take that must be ignored.
        taken.delete();
        for (int i = 0; i < 3; i++) take_one();
        restart = 1'b1; take = 1'b1;
        cyc();
        restart = 1'b0;
        check("restart_valid", 32'(piece_valid), 32'd0);
        check("restart_bag_left", 32'(bag_left), 32'd7);
        check("restart_count", 32'(dbg_count), 32'd0);
        cyc();
        take = 1'b0;
        check("empty_take_count", 32'(dbg_count), 32'd0);
        check("empty_take_valid", 32'(piece_valid), 32'd0);
        taken.delete();
        for (int i = 0; i < 7; i++) take_one();
        if (taken.size() == 7) check_perm("restart_perm", 0);
        else check("restart_taken", 32'(taken.size()), 32'd7);

        // Fill to full and hold.
        w = 0;
        while (dbg_count != 4'd3 && w < 300) begin cyc(); w++; end
        check("reach_full", 32'(dbg_count), 32'd3);
        repeat (100) cyc();
        check("hold_count", 32'(dbg_count), 32'd3);
        check("hold_state", 32'(dbg_state), 32'(PBQ_FULL));
        take_one();
        w = 0;
        while (dbg_count != 4'd3 && w < 300) begin cyc(); w++; end
        check("refill_count", 32'(dbg_count), 32'd3);

        // Asynchronous reset mid-cycle takes effect immediately.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_piece", 32'(piece), 32'd7);
        check("arst_valid", 32'(piece_valid), 32'd0);
        check("arst_bag_left", 32'(bag_left), 32'd7);
        check("arst_count", 32'(dbg_count), 32'd0);
        cyc();
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("rearm_piece", 32'(piece), 32'd1);
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
